// File: rtl/q_ringdown_meter_pkg.sv
// Shared types and constants for the ring-down Q meter: FSM state encoding,
// counter-width helper and default bus/timeout sizing.
package q_meter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXCITE  = 3'd1,
    WAIT_HI = 3'd2,
    COUNT   = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int DEF_BUS_WIDTH      = 10;
  localparam int DEF_TIMEOUT_CYCLES = 65535;
  localparam int SYNC_STAGES        = 2;

  // Bits needed to hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int DEF_TO_W = cnt_width(DEF_TIMEOUT_CYCLES);
  localparam int Q_MAX    = (1 << DEF_BUS_WIDTH) - 1;

endpackage

// File: rtl/q_ringdown_meter_sync_edge.sv
// N-stage synchroniser for an asynchronous level, plus a registered
// rising-edge pulse derived from the synchronised value.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = rise_q;

endmodule

// File: rtl/q_ringdown_meter.sv
// Ring-down Q meter: excite, wait for envelope to drop below HI, count osc
// edges until it drops below LO. Define Q_AVG_EN to average 2^AVG_LOG2 runs.
module q_ringdown_meter
  import q_meter_pkg::*;
#(
  parameter int BUS_WIDTH      = DEF_BUS_WIDTH,
  parameter int EXCITE_CYCLES  = 64,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int AVG_LOG2       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 osc_cmp,
  input  logic                 env_hi,
  input  logic                 env_lo,
  output logic                 excite,
  output logic [BUS_WIDTH-1:0] q_measured,
  output logic                 ready,
  output logic                 meas_fault,
  output logic                 busy,
  output logic [2:0]           state_dbg
);

  localparam int EXC_W = cnt_width(EXCITE_CYCLES);
  localparam int TO_W  = cnt_width(TIMEOUT_CYCLES);
  localparam logic [EXC_W-1:0]     EXC_LAST = EXC_W'(EXCITE_CYCLES - 1);
  localparam logic [TO_W-1:0]      TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BUS_WIDTH-1:0] Q_SAT    = {BUS_WIDTH{1'b1}};

  logic osc_s, osc_rise, env_hi_s, hi_rise, env_lo_s, lo_rise;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_osc (
    .clk(clk), .rst(rst), .d_i(osc_cmp), .sync_o(osc_s), .rise_o(osc_rise));
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_hi (
    .clk(clk), .rst(rst), .d_i(env_hi), .sync_o(env_hi_s), .rise_o(hi_rise));
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lo (
    .clk(clk), .rst(rst), .d_i(env_lo), .sync_o(env_lo_s), .rise_o(lo_rise));

  logic unused_sync;
  assign unused_sync = ^{osc_s, hi_rise, lo_rise};

  state_t               state_q, state_d;
  logic [EXC_W-1:0]     exc_cnt_q, exc_cnt_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [BUS_WIDTH-1:0] q_cnt_q, q_cnt_d;
  logic [BUS_WIDTH-1:0] q_meas_q;
  logic                 fault_q, ready_q;
  logic                 fin_fault, done_go, to_last;
  logic                 report;
  logic [BUS_WIDTH-1:0] rpt_val;

  assign to_last = (to_cnt_q == TO_LAST);
  assign done_go = (state_d == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A low HI flag on the very first WAIT_HI cycle means the burst never
  // pushed the envelope above HI, which is reported as a fault.
  always_comb begin
    state_d   = state_q;
    fin_fault = 1'b0;
    case (state_q)
      IDLE:    if (enable) state_d = EXCITE;
      EXCITE:  if (exc_cnt_q == EXC_LAST) state_d = WAIT_HI;
      WAIT_HI: begin
        if (!env_hi_s && to_cnt_q == '0) begin
          state_d   = DONE;
          fin_fault = 1'b1;
        end else if (!env_hi_s) begin
          state_d = COUNT;
        end else if (to_last) begin
          state_d   = DONE;
          fin_fault = 1'b1;
        end
      end
      COUNT: begin
        if (!env_lo_s) begin
          state_d = DONE;
        end else if (to_last) begin
          state_d   = DONE;
          fin_fault = 1'b1;
        end
      end
      DONE:    state_d = enable ? EXCITE : IDLE;
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  always_comb begin
    excite    = (state_q == EXCITE);
    busy      = (state_q != IDLE);
    state_dbg = state_q;
  end

  // q_cnt_d already includes an edge arriving in the exit cycle, so it is
  // the value latched when entering DONE.
  always_comb begin
    exc_cnt_d = (state_q == EXCITE) ? exc_cnt_q + 1'b1 : '0;
    to_cnt_d  = (state_q == WAIT_HI || state_q == COUNT) ? to_cnt_q + 1'b1 : '0;
    q_cnt_d   = '0;
    if (state_q == COUNT) begin
      q_cnt_d = (osc_rise && q_cnt_q != Q_SAT) ? q_cnt_q + 1'b1 : q_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc_cnt_q <= '0;
      to_cnt_q  <= '0;
      q_cnt_q   <= '0;
    end else begin
      exc_cnt_q <= exc_cnt_d;
      to_cnt_q  <= to_cnt_d;
      q_cnt_q   <= q_cnt_d;
    end
  end

`ifdef Q_AVG_EN
  localparam int ACC_W = BUS_WIDTH + AVG_LOG2;
  logic [ACC_W-1:0]    acc_q, acc_d, acc_sum;
  logic [AVG_LOG2-1:0] round_q, round_d;

  // Only the last round of a batch reports; a fault reports at once and
  // restarts the batch.
  always_comb begin
    acc_sum = acc_q + ACC_W'(q_cnt_d);
    acc_d   = acc_q;
    round_d = round_q;
    report  = 1'b0;
    rpt_val = '0;
    if (!enable) begin
      acc_d   = '0;
      round_d = '0;
    end else if (done_go) begin
      if (fin_fault) begin
        acc_d   = '0;
        round_d = '0;
        report  = 1'b1;
      end else if (round_q == {AVG_LOG2{1'b1}}) begin
        rpt_val = acc_sum[ACC_W-1:AVG_LOG2];
        acc_d   = '0;
        round_d = '0;
        report  = 1'b1;
      end else begin
        acc_d   = acc_sum;
        round_d = round_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      round_q <= '0;
    end else begin
      acc_q   <= acc_d;
      round_q <= round_d;
    end
  end
`else
  logic [31:0] unused_avg_cfg;
  assign unused_avg_cfg = AVG_LOG2;
  assign report  = 1'b1;
  assign rpt_val = fin_fault ? '0 : q_cnt_d;
`endif

  // ready is registered on DONE entry, so it lines up with the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_meas_q <= '0;
      fault_q  <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      ready_q <= done_go & report;
      if (done_go && report) begin
        q_meas_q <= rpt_val;
        fault_q  <= fin_fault;
      end
    end
  end

  assign q_measured = q_meas_q;
  assign meas_fault = fault_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_q_ringdown_meter.sv
// Bench for q_ringdown_meter: two instances (10-bit and 4-bit bus) share one
// stimulus; a reference model pushes expected reports, a monitor pops them.
module tb_q_ringdown_meter;

  localparam int BW_A   = 10;
  localparam int BW_B   = 4;
  localparam int EXC    = 64;
  localparam int TO     = 1000;
  localparam int QMAX_A = (1 << BW_A) - 1;
  localparam int QMAX_B = (1 << BW_B) - 1;

  localparam int M_NORM    = 0;
  localparam int M_COINC   = 1;
  localparam int M_NOHI    = 2;
  localparam int M_TIMEOUT = 3;

  logic clk, rst, enable, osc_cmp, env_hi, env_lo;
  logic excite_a, ready_a, fault_a, busy_a;
  logic excite_b, ready_b, fault_b, busy_b;
  logic [BW_A-1:0] q_a;
  logic [BW_B-1:0] q_b;
  logic [2:0] state_a, state_b;

  logic [BW_A:0] exp_a_q[$];
  logic [BW_B:0] exp_b_q[$];
  int n_vec = 0;
  int n_err = 0;
  int last_a = 0;
  int last_b = 0;
  logic prev_rdy_a = 1'b0;
  logic prev_rdy_b = 1'b0;
`ifdef Q_AVG_EN
  int acc_a = 0;
  int acc_b = 0;
  int rnd = 0;
`endif

  q_ringdown_meter #(.BUS_WIDTH(BW_A), .EXCITE_CYCLES(EXC), .TIMEOUT_CYCLES(TO), .AVG_LOG2(2)) u_dut_a (
    .clk(clk), .rst(rst), .enable(enable), .osc_cmp(osc_cmp), .env_hi(env_hi), .env_lo(env_lo),
    .excite(excite_a), .q_measured(q_a), .ready(ready_a), .meas_fault(fault_a), .busy(busy_a),
    .state_dbg(state_a));

  q_ringdown_meter #(.BUS_WIDTH(BW_B), .EXCITE_CYCLES(EXC), .TIMEOUT_CYCLES(TO), .AVG_LOG2(2)) u_dut_b (
    .clk(clk), .rst(rst), .enable(enable), .osc_cmp(osc_cmp), .env_hi(env_hi), .env_lo(env_lo),
    .excite(excite_b), .q_measured(q_b), .ready(ready_b), .meas_fault(fault_b), .busy(busy_b),
    .state_dbg(state_b));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model
  task automatic push_result(input int n, input bit fault);
    int qa, qb;
    qa = (n > QMAX_A) ? QMAX_A : n;
    qb = (n > QMAX_B) ? QMAX_B : n;
`ifdef Q_AVG_EN
    if (fault) begin
      exp_a_q.push_back({1'b1, {BW_A{1'b0}}});
      exp_b_q.push_back({1'b1, {BW_B{1'b0}}});
      acc_a = 0;
      acc_b = 0;
      rnd   = 0;
    end else begin
      acc_a += qa;
      acc_b += qb;
      rnd++;
      if (rnd == 4) begin
        exp_a_q.push_back({1'b0, BW_A'(acc_a >> 2)});
        exp_b_q.push_back({1'b0, BW_B'(acc_b >> 2)});
        acc_a = 0;
        acc_b = 0;
        rnd   = 0;
      end
    end
`else
    if (fault) begin
      exp_a_q.push_back({1'b1, {BW_A{1'b0}}});
      exp_b_q.push_back({1'b1, {BW_B{1'b0}}});
    end else begin
      exp_a_q.push_back({1'b0, BW_A'(qa)});
      exp_b_q.push_back({1'b0, BW_B'(qb)});
    end
`endif
  endtask

  task automatic model_abort();
`ifdef Q_AVG_EN
    acc_a = 0;
    acc_b = 0;
    rnd   = 0;
`endif
  endtask

  // scoreboard monitor
  always @(negedge clk) begin : mon
    logic [BW_A:0] ea;
    logic [BW_B:0] eb;
    if (!rst) begin
      if (ready_a) begin
        check("a_rdy_gap", 32'(prev_rdy_a), 0);
        check("a_rdy_expected", 32'(exp_a_q.size() != 0), 1);
        if (exp_a_q.size() != 0) begin
          ea = exp_a_q.pop_front();
          check("a_q", 32'(q_a), 32'(ea[BW_A-1:0]));
          check("a_fault", 32'(fault_a), 32'(ea[BW_A]));
          last_a = int'(ea[BW_A-1:0]);
        end
      end
      if (ready_b) begin
        check("b_rdy_gap", 32'(prev_rdy_b), 0);
        check("b_rdy_expected", 32'(exp_b_q.size() != 0), 1);
        if (exp_b_q.size() != 0) begin
          eb = exp_b_q.pop_front();
          check("b_q", 32'(q_b), 32'(eb[BW_B-1:0]));
          check("b_fault", 32'(fault_b), 32'(eb[BW_B]));
          last_b = int'(eb[BW_B-1:0]);
        end
      end
    end
    prev_rdy_a = ready_a;
    prev_rdy_b = ready_b;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_osc(input bit drop_lo);
    osc_cmp = 1'b1;
    tick(1);
    if (drop_lo) env_lo = 1'b0;
    tick(1);
    osc_cmp = 1'b0;
    tick(2);
  endtask

  // Waits for the burst, checks its length, leaves the bench at the first
  // WAIT_HI cycle.
  task automatic wait_burst(input bit hi_level);
    int k;
    k = 0;
    while (!excite_a && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("excite_seen", 32'(excite_a), 1);
    env_hi  = hi_level;
    env_lo  = 1'b1;
    osc_cmp = 1'b0;
    k = 0;
    while (excite_a && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("excite_len", k, EXC);
  endtask

  task automatic meas(input int n, input int mode);
    int k;
    wait_burst(mode != M_NOHI);
    case (mode)
      M_NOHI: push_result(0, 1'b1);
      M_TIMEOUT: begin
        push_result(0, 1'b1);
        env_hi = 1'b0;
        k = 0;
        while (!ready_a && k < 1200) begin
          @(negedge clk);
          k++;
        end
        check("timeout_len", k, TO);
      end
      default: begin
        push_result(n, 1'b0);
        tick(3);
        env_hi = 1'b0;
        tick(4);
        for (int i = 0; i < n; i++) pulse_osc(mode == M_COINC && i == n - 1);
        if (mode != M_COINC) begin
          tick(2);
          env_lo = 1'b0;
        end
      end
    endcase
  endtask

  task automatic enter_count();
    wait_burst(1'b1);
    tick(3);
    env_hi = 1'b0;
    tick(4);
    for (int i = 0; i < 3; i++) pulse_osc(1'b0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; osc_cmp = 1'b0; env_hi = 1'b0; env_lo = 1'b0;
    tick(3);
    check("rst_q_a", 32'(q_a), 0);
    check("rst_q_b", 32'(q_b), 0);
    check("rst_ready_a", 32'(ready_a), 0);
    check("rst_fault_a", 32'(fault_a), 0);
    check("rst_busy_a", 32'(busy_a), 0);
    check("rst_excite_a", 32'(excite_a), 0);
    check("rst_state_a", 32'(state_a), 0);
    rst = 1'b0;
    tick(1);
    enable = 1'b1;

    meas(37, M_NORM);
    meas(5, M_COINC);
    meas(20, M_NORM);
    meas(0, M_NOHI);
    meas(0, M_TIMEOUT);
    meas(10, M_NORM);
    meas(11, M_NORM);
    meas(12, M_NORM);
    meas(14, M_NORM);
    meas(37, M_NORM);

    // drop enable in COUNT
    enter_count();
    enable = 1'b0;
    model_abort();
    tick(1);
    check("abort_excite", 32'(excite_a), 0);
    check("abort_busy_a", 32'(busy_a), 0);
    check("abort_busy_b", 32'(busy_b), 0);
    check("abort_q_a", 32'(q_a), 32'(last_a));
    check("abort_q_b", 32'(q_b), 32'(last_b));
    tick(20);
    enable = 1'b1;

    // drop enable during the burst
    wait_burst(1'b1);
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
    model_abort();
    tick(1);
    check("abort_exc_excite", 32'(excite_a), 0);
    check("abort_exc_state", 32'(state_a), 0);
    tick(10);
    enable = 1'b1;
    meas(23, M_NORM);

    // asynchronous reset in COUNT
    enter_count();
    rst = 1'b1;
    #1;
    check("arst_q_a", 32'(q_a), 0);
    check("arst_q_b", 32'(q_b), 0);
    check("arst_excite", 32'(excite_a), 0);
    check("arst_busy", 32'(busy_a), 0);
    check("arst_ready", 32'(ready_a), 0);
    check("arst_fault", 32'(fault_a), 0);
    exp_a_q.delete();
    exp_b_q.delete();
    last_a = 0;
    last_b = 0;
    model_abort();
    osc_cmp = 1'b0;
    tick(2);
    rst = 1'b0;

    meas(37, M_NORM);
    tick(12);
    enable = 1'b0;
    tick(4);
    check("a_drained", exp_a_q.size(), 0);
    check("b_drained", exp_b_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
